decade_div_ctrl: RTL and testbench

Controller that sequences a cascade of BCD decade stages as one synchronous clock-enable divider. It produces a single-cycle `tick` every 1, 10, 100 or 1000 `clk` cycles, selected at run time. The block replaces ripple-clocked decade cascades: every stage runs on `clk`, and each stage advances only on the terminal count of the stages below it. It sits between the system clock domain and any consumer that needs a slow strobe, for example deriving 1 Hz from 1 kHz.

---
 rtl/decade_div_ctrl_if.sv | 40 ++++
 rtl/decade_div_ctrl.sv | 129 ++++++++++++
 tb/tb_decade_div_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decade_div_ctrl_if.sv
// Handshake and status bundle for the decade divider controller.
// The master side issues start/stop and divide-select requests; the slave side
// (the controller) returns the handshake ready, run status, tick and BCD count.
interface decade_div_ctrl_if #(
    parameter int STAGES = 3
) ();
    logic                  start;
    logic                  stop;
    logic                  cfg_valid;
    logic [1:0]            cfg_sel;
    logic                  cfg_ready;
    logic                  busy;
    logic                  tick;
    logic [1:0]            div_sel;
    logic [4*STAGES-1:0]   count;

    modport master (
        output start,
        output stop,
        output cfg_valid,
        output cfg_sel,
        input  cfg_ready,
        input  busy,
        input  tick,
        input  div_sel,
        input  count
    );

    modport slave (
        input  start,
        input  stop,
        input  cfg_valid,
        input  cfg_sel,
        output cfg_ready,
        output busy,
        output tick,
        output div_sel,
        output count
    );
endinterface

// File: rtl/decade_div_ctrl.sv
// Synchronous BCD decade cascade used as a clock-enable divider.
// Produces a one-cycle tick every 10^div_sel clocks; all stages run on clk and
// a digit advances only when every lower active digit sits at 9.
module decade_div_ctrl #(
    parameter int STAGES = 3
) (
    input  logic               clk,
    input  logic               reset,
    decade_div_ctrl_if.slave   bus
);
    localparam int         W       = 4 * STAGES;
    localparam logic [1:0] MAX_SEL = 2'(STAGES);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t       state_q, state_n;
    logic [W-1:0] count_q, count_n, count_inc;
    logic         tick_q, tick_n;
    logic [1:0]   div_sel_q, div_sel_n;
    logic [1:0]   pend_sel_q, pend_sel_n;
    logic         pend_q, pend_n;
    logic [1:0]   cfg_sel_sat;
    logic         accept;
    logic         carry;
    logic         term_cnt;

    // Requested select clamped to the number of stages actually built.
    always_comb begin
        cfg_sel_sat = (bus.cfg_sel > MAX_SEL) ? MAX_SEL : bus.cfg_sel;
    end

    // A request is taken whenever nothing is already waiting to be applied.
    assign accept = bus.cfg_valid && !pend_q;

    // Carry chain over the active digits; the carry out of the last active
    // digit means every active digit is 9, i.e. terminal count.
    always_comb begin
        count_inc = '0;
        carry     = 1'b1;
        for (int i = 0; i < STAGES; i++) begin
            if (2'(i) < div_sel_q) begin
                if (carry) begin
                    count_inc[4*i +: 4] = (count_q[4*i +: 4] == 4'd9) ? 4'd0
                                                                       : count_q[4*i +: 4] + 4'd1;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4];
                end
                carry = carry && (count_q[4*i +: 4] == 4'd9);
            end
        end
        term_cnt = carry;
    end

    // Next-state, counter and configuration update logic.
    always_comb begin
        state_n    = state_q;
        count_n    = count_q;
        tick_n     = 1'b0;
        div_sel_n  = div_sel_q;
        pend_n     = pend_q;
        pend_sel_n = pend_sel_q;
        case (state_q)
            IDLE: begin
                count_n = '0;
                if (accept) begin
                    div_sel_n = cfg_sel_sat;
                end
                if (bus.start && !bus.stop) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_n = IDLE;
                    count_n = '0;
                    if (pend_q) begin
                        div_sel_n = pend_sel_q;
                        pend_n    = 1'b0;
                    end else if (accept) begin
                        div_sel_n = cfg_sel_sat;
                    end
                end else begin
                    count_n = count_inc;
                    tick_n  = term_cnt;
                    if (term_cnt && pend_q) begin
                        div_sel_n = pend_sel_q;
                        pend_n    = 1'b0;
                    end
                    if (accept) begin
                        pend_n     = 1'b1;
                        pend_sel_n = cfg_sel_sat;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                count_n = '0;
            end
        endcase
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            tick_q     <= 1'b0;
            div_sel_q  <= MAX_SEL;
            pend_q     <= 1'b0;
            pend_sel_q <= 2'd0;
        end else begin
            state_q    <= state_n;
            count_q    <= count_n;
            tick_q     <= tick_n;
            div_sel_q  <= div_sel_n;
            pend_q     <= pend_n;
            pend_sel_q <= pend_sel_n;
        end
    end

    assign bus.cfg_ready = !pend_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.tick      = tick_q;
    assign bus.div_sel   = div_sel_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_decade_div_ctrl.sv
// Directed testbench for decade_div_ctrl: a 3-stage instance carries most of
// the sequence, a 2-stage instance covers select saturation.
module tb_decade_div_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    decade_div_ctrl_if #(.STAGES(3)) bus3 ();
    decade_div_ctrl_if #(.STAGES(2)) bus2 ();

    decade_div_ctrl #(.STAGES(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    decade_div_ctrl #(.STAGES(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    // 10-time-unit clock.
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_config(input logic [1:0] sel);
        bus3.cfg_valid = 1'b1;
        bus3.cfg_sel   = sel;
        step(1);
        bus3.cfg_valid = 1'b0;
    endtask

    // Leaves the bench just after E0.
    task automatic apply_start();
        bus3.start = 1'b1;
        step(1);
        bus3.start = 1'b0;
    endtask

    task automatic apply_stop();
        bus3.stop = 1'b1;
        step(1);
        bus3.stop = 1'b0;
    endtask

    initial begin
        bus3.start = 1'b0; bus3.stop = 1'b0; bus3.cfg_valid = 1'b0; bus3.cfg_sel = 2'd0;
        bus2.start = 1'b0; bus2.stop = 1'b0; bus2.cfg_valid = 1'b0; bus2.cfg_sel = 2'd0;
        #13;
        check_output("rst_busy",    32'(bus3.busy), 0);
        check_output("rst_count",   32'(bus3.count), 0);
        check_output("rst_tick",    32'(bus3.tick), 0);
        check_output("rst_div_sel", 32'(bus3.div_sel), 3);
        check_output("rst_ready",   32'(bus3.cfg_ready), 1);
        check_output("rst_div2",    32'(bus2.div_sel), 2);
        @(posedge clk); #1;
        reset = 1'b1;
        step(1);

        // Divide by 1000 with the default select.
        apply_start();
        check_output("k_busy_e0",  32'(bus3.busy), 1);
        check_output("k_count_e0", 32'(bus3.count), 0);
        step(9);
        check_output("k_count_009", 32'(bus3.count), 'h009);
        step(1);
        check_output("k_count_010", 32'(bus3.count), 'h010);
        step(89);
        check_output("k_count_099", 32'(bus3.count), 'h099);
        step(1);
        check_output("k_count_100", 32'(bus3.count), 'h100);
        step(899);
        check_output("k_count_999", 32'(bus3.count), 'h999);
        check_output("k_tick_999",  32'(bus3.tick), 0);
        step(1);
        check_output("k_tick_1000",  32'(bus3.tick), 1);
        check_output("k_count_1000", 32'(bus3.count), 0);
        step(1);
        check_output("k_tick_1001",  32'(bus3.tick), 0);
        check_output("k_count_1001", 32'(bus3.count), 1);
        step(999);
        check_output("k_tick_2000", 32'(bus3.tick), 1);
        apply_stop();
        check_output("stop_busy",  32'(bus3.busy), 0);
        check_output("stop_count", 32'(bus3.count), 0);
        check_output("stop_tick",  32'(bus3.tick), 0);

        // Divide by 10 selected in IDLE.
        apply_config(2'd1);
        check_output("d10_sel", 32'(bus3.div_sel), 1);
        apply_start();
        step(9);
        check_output("d10_tick_e9",  32'(bus3.tick), 0);
        check_output("d10_count_e9", 32'(bus3.count), 9);
        step(1);
        check_output("d10_tick_e10", 32'(bus3.tick), 1);
        step(5);
        check_output("d10_upper_e15", 32'(bus3.count[11:4]), 0);
        step(5);
        check_output("d10_tick_e20", 32'(bus3.tick), 1);
        step(1);
        check_output("d10_tick_e21", 32'(bus3.tick), 0);
        step(9);
        check_output("d10_tick_e30", 32'(bus3.tick), 1);
        apply_stop();

        // Reconfigure 100 -> 10 while running.
        apply_config(2'd2);
        apply_start();
        step(37);
        check_output("rc_count_37", 32'(bus3.count), 'h37);
        bus3.cfg_valid = 1'b1;
        bus3.cfg_sel   = 2'd1;
        step(1);
        bus3.cfg_valid = 1'b0;
        check_output("rc_ready_38", 32'(bus3.cfg_ready), 0);
        check_output("rc_count_38", 32'(bus3.count), 'h38);
        step(61);
        check_output("rc_count_99", 32'(bus3.count), 'h99);
        check_output("rc_ready_99", 32'(bus3.cfg_ready), 0);
        check_output("rc_sel_99",   32'(bus3.div_sel), 2);
        check_output("rc_tick_99",  32'(bus3.tick), 0);
        step(1);
        check_output("rc_tick_100",  32'(bus3.tick), 1);
        check_output("rc_sel_100",   32'(bus3.div_sel), 1);
        check_output("rc_ready_100", 32'(bus3.cfg_ready), 1);
        check_output("rc_count_100", 32'(bus3.count), 0);
        step(10);
        check_output("rc_tick_110", 32'(bus3.tick), 1);
        step(9);
        check_output("rc_tick_119", 32'(bus3.tick), 0);
        step(1);
        check_output("rc_tick_120", 32'(bus3.tick), 1);
        apply_stop();

        // Stop with a pending request.
        apply_config(2'd3);
        apply_start();
        step(100);
        bus3.cfg_valid = 1'b1;
        bus3.cfg_sel   = 2'd1;
        step(1);
        bus3.cfg_valid = 1'b0;
        step(148);
        check_output("sp_count_249", 32'(bus3.count), 'h249);
        check_output("sp_ready_249", 32'(bus3.cfg_ready), 0);
        apply_stop();
        check_output("sp_busy",  32'(bus3.busy), 0);
        check_output("sp_sel",   32'(bus3.div_sel), 1);
        check_output("sp_ready", 32'(bus3.cfg_ready), 1);
        check_output("sp_tick",  32'(bus3.tick), 0);
        check_output("sp_count", 32'(bus3.count), 0);

        // Stop landing on a terminal-count edge suppresses the tick.
        apply_start();
        step(9);
        check_output("stc_count_9", 32'(bus3.count), 9);
        apply_stop();
        check_output("stc_tick", 32'(bus3.tick), 0);
        check_output("stc_busy", 32'(bus3.busy), 0);

        // Divide by 1: tick every cycle from E1.
        apply_config(2'd0);
        check_output("d1_sel", 32'(bus3.div_sel), 0);
        apply_start();
        check_output("d1_tick_e0", 32'(bus3.tick), 0);
        step(1);
        check_output("d1_tick_e1",  32'(bus3.tick), 1);
        check_output("d1_count_e1", 32'(bus3.count), 0);
        step(1);
        check_output("d1_tick_e2", 32'(bus3.tick), 1);
        apply_stop();
        check_output("d1_tick_stop", 32'(bus3.tick), 0);

        // Start and stop together in IDLE stays idle.
        bus3.start = 1'b1;
        bus3.stop  = 1'b1;
        step(1);
        bus3.start = 1'b0;
        bus3.stop  = 1'b0;
        check_output("ss_busy", 32'(bus3.busy), 0);

        // Saturation of the select on the 2-stage instance.
        bus2.cfg_valid = 1'b1;
        bus2.cfg_sel   = 2'd3;
        step(1);
        bus2.cfg_sel   = 2'd1;
        check_output("sat_sel3", 32'(bus2.div_sel), 2);
        step(1);
        bus2.cfg_valid = 1'b0;
        check_output("sat_sel1", 32'(bus2.div_sel), 1);

        // Asynchronous reset mid-period with a request pending.
        apply_config(2'd3);
        apply_start();
        step(400);
        bus3.cfg_valid = 1'b1;
        bus3.cfg_sel   = 2'd1;
        step(1);
        bus3.cfg_valid = 1'b0;
        step(56);
        check_output("ar_count_457", 32'(bus3.count), 'h457);
        check_output("ar_ready_457", 32'(bus3.cfg_ready), 0);
        #2;
        reset = 1'b0;
        #1;
        check_output("ar_count", 32'(bus3.count), 0);
        check_output("ar_busy",  32'(bus3.busy), 0);
        check_output("ar_tick",  32'(bus3.tick), 0);
        check_output("ar_sel",   32'(bus3.div_sel), 3);
        check_output("ar_ready", 32'(bus3.cfg_ready), 1);
        check_output("ar_sel2",  32'(bus2.div_sel), 2);
        step(2);
        reset = 1'b1;
        step(1);
        apply_start();
        check_output("ar2_busy",  32'(bus3.busy), 1);
        check_output("ar2_count", 32'(bus3.count), 0);
        step(999);
        check_output("ar2_count_999", 32'(bus3.count), 'h999);
        step(1);
        check_output("ar2_tick_1000", 32'(bus3.tick), 1);
        apply_stop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
